// File: rtl/audio_output_stage.sv
// audio_output_stage
// Turns per-channel effect pulse trains into square waves, picks the highest
// priority enabled channel that is sounding, and drives the speaker pin with
// that square wave gated by a volume-controlled PWM carrier.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   pulse_in     per-channel pulse trains (rising-edge sensitive)
//   ch_enable    per-channel eligibility mask (selection only)
//   volume       PWM duty threshold, 0 = silent
//   active       per-channel tone-present flags (registered)
//   speaker_out  PWM-modulated square wave (registered)
module audio_output_stage #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned SILENCE_TIMEOUT = 65536,
    parameter int unsigned PWM_BITS        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   pulse_in,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [PWM_BITS-1:0] volume,
    output logic [NUM_CH-1:0]   active,
    output logic                speaker_out
);

    localparam int unsigned CNT_W = $clog2(SILENCE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SILENCE_TIMEOUT - 1);

    logic [NUM_CH-1:0]   pulse_prev_q;
    logic [NUM_CH-1:0]   phase_q, phase_d;
    logic [NUM_CH-1:0]   active_q, active_d;
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                speaker_q, speaker_d;

    logic [NUM_CH-1:0]   edge_c;
    logic                any_sel_c;
    logic                sel_phase_c;
    logic                pwm_hi_c;

    // A level held high produces a single edge.
    assign edge_c = pulse_in & ~pulse_prev_q;

    // Per-channel tone tracking; an edge outranks a coincident timeout.
    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (edge_c[i]) begin
                phase_d[i]  = ~phase_q[i];
                cnt_d[i]    = '0;
                active_d[i] = 1'b1;
            end else if (active_q[i] && (cnt_q[i] == CNT_LAST)) begin
                phase_d[i]  = 1'b0;
                cnt_d[i]    = '0;
                active_d[i] = 1'b0;
            end else if (active_q[i]) begin
                cnt_d[i]    = cnt_q[i] + CNT_W'(1);
            end else begin
                phase_d[i]  = 1'b0;
                cnt_d[i]    = '0;
                active_d[i] = 1'b0;
            end
        end
    end

    // Fixed priority: scanning downward leaves the lowest eligible index.
    always_comb begin
        any_sel_c   = 1'b0;
        sel_phase_c = 1'b0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (active_q[i] && ch_enable[i]) begin
                any_sel_c   = 1'b1;
                sel_phase_c = phase_q[i];
            end
        end
    end

    // Free-running PWM carrier; all-ones volume still leaves one low cycle.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_hi_c  = (pwm_cnt_q < volume);
        speaker_d = any_sel_c & sel_phase_c & pwm_hi_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_prev_q <= '0;
            phase_q      <= '0;
            active_q     <= '0;
            pwm_cnt_q    <= '0;
            speaker_q    <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pulse_prev_q <= pulse_in;
            phase_q      <= phase_d;
            active_q     <= active_d;
            pwm_cnt_q    <= pwm_cnt_d;
            speaker_q    <= speaker_d;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign active      = active_q;
    assign speaker_out = speaker_q;

endmodule

// File: tb/tb_audio_output_stage.sv
// Testbench for audio_output_stage: a timestamp-based reference model predicts
// active flags and speaker output every cycle under directed and random stimulus.
module tb_audio_output_stage;

    localparam int NCH = 4;
    localparam int T   = 16;

    logic           clk;
    logic           reset_n;
    logic [NCH-1:0] pulse_in;
    logic [NCH-1:0] ch_enable;
    logic [7:0]     volume;
    logic [NCH-1:0] active;
    logic           speaker_out;

    int n_checks = 0;
    int n_errors = 0;

    // Model: cycle index since reset release, last edge time and tone phase.
    int p;
    int last_e [NCH];
    bit ph     [NCH];
    bit prevp  [NCH];

    audio_output_stage #(
        .NUM_CH(NCH),
        .SILENCE_TIMEOUT(T),
        .PWM_BITS(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pulse_in(pulse_in),
        .ch_enable(ch_enable),
        .volume(volume),
        .active(active),
        .speaker_out(speaker_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // A channel sounds for T cycles after the cycle following its last edge.
    function automatic bit m_active(int i, int t);
        return (last_e[i] >= 0) && (t - last_e[i] >= 1) && (t - last_e[i] <= T);
    endfunction

    // Advance one clock; return what the model predicts for the new cycle.
    task automatic tick(output logic [NCH-1:0] ea, output logic es);
        bit nxt;
        bit found;
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                last_e[i] = -1;
                ph[i]     = 1'b0;
                prevp[i]  = 1'b0;
            end
            p = 0;
            @(posedge clk);
            #1;
            ea = '0;
            es = 1'b0;
            return;
        end
        nxt   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && m_active(i, p) && ch_enable[i]) begin
                found = 1'b1;
                nxt   = ph[i] && ((p % 256) < int'(volume));
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (pulse_in[i] && !prevp[i]) begin
                ph[i]     = m_active(i, p) ? ~ph[i] : 1'b1;
                last_e[i] = p;
            end
            prevp[i] = pulse_in[i];
        end
        @(posedge clk);
        #1;
        p++;
        for (int i = 0; i < NCH; i++) ea[i] = m_active(i, p);
        es = nxt;
    endtask

    task automatic quiet(int n);
        logic [NCH-1:0] ea;
        logic es;
        pulse_in = '0;
        for (int j = 0; j < n; j++) tick(ea, es);
    endtask

    task automatic test_reset();
        logic [NCH-1:0] ea;
        logic es;
        reset_n   = 1'b0;
        ch_enable = '1;
        volume    = 8'd255;
        for (int j = 0; j < 8; j++) begin
            pulse_in = (j % 2 == 0) ? 4'hF : 4'h0;
            tick(ea, es);
            n_checks += 2;
            if (active !== 4'h0) begin n_errors++; $display("FAIL reset.active j=%0d got=%b exp=0000", j, active); end
            if (speaker_out !== 1'b0) begin n_errors++; $display("FAIL reset.speaker j=%0d got=%b exp=0", j, speaker_out); end
        end
        pulse_in = '0;
        reset_n  = 1'b1;
        pulse_in = 4'b0001;
        tick(ea, es);
        pulse_in = '0;
        n_checks += 2;
        if (active !== 4'b0001) begin n_errors++; $display("FAIL reset.first_pulse got=%b exp=0001", active); end
        if (active !== ea) begin n_errors++; $display("FAIL reset.model got=%b exp=%b", active, ea); end
    endtask

    task automatic test_single_tone();
        logic [NCH-1:0] ea;
        logic es;
        int per;
        int first_hi;
        quiet(T + 4);
        ch_enable = '1;
        volume    = 8'd255;
        per       = $urandom_range(4, 15);
        if (((p + 1) % 256) == 255) quiet(1);
        first_hi = -1;
        for (int j = 0; j < 300; j++) begin
            pulse_in[0] = (j % per == 0);
            tick(ea, es);
            if (speaker_out === 1'b1 && first_hi < 0) first_hi = j + 1;
            n_checks += 2;
            if (active !== ea) begin n_errors++; $display("FAIL tone.active p=%0d got=%b exp=%b", p, active, ea); end
            if (speaker_out !== es) begin n_errors++; $display("FAIL tone.speaker p=%0d got=%b exp=%b", p, speaker_out, es); end
        end
        pulse_in = '0;
        n_checks++;
        if (first_hi !== 2) begin n_errors++; $display("FAIL tone.first_assert got=%0d exp=2", first_hi); end
    endtask

    task automatic test_timeout();
        logic [NCH-1:0] ea;
        logic es;
        quiet(T + 4);
        ch_enable = '1;
        volume    = 8'd255;
        pulse_in  = 4'b0010;
        for (int j = 1; j <= 22; j++) begin
            tick(ea, es);
            pulse_in = '0;
            n_checks += 3;
            if (active[1] !== (j <= T)) begin n_errors++; $display("FAIL timeout.active1 k+%0d got=%b exp=%b", j, active[1], (j <= T)); end
            if (active !== ea) begin n_errors++; $display("FAIL timeout.model_active k+%0d got=%b exp=%b", j, active, ea); end
            if (speaker_out !== es || (j >= T + 2 && speaker_out !== 1'b0)) begin
                n_errors++; $display("FAIL timeout.speaker k+%0d got=%b exp=%b", j, speaker_out, es);
            end
        end
    endtask

    task automatic test_collision();
        logic [NCH-1:0] ea;
        logic es;
        quiet(T + 4);
        ch_enable = 4'b0100;
        volume    = 8'd255;
        for (int j = 0; j < 40; j++) begin
            pulse_in[2] = (j == 0 || j == T);
            tick(ea, es);
            n_checks += 3;
            if (active[2] !== (j + 1 <= 2 * T)) begin n_errors++; $display("FAIL collision.active2 k+%0d got=%b exp=%b", j + 1, active[2], (j + 1 <= 2 * T)); end
            if (speaker_out !== es) begin n_errors++; $display("FAIL collision.speaker k+%0d got=%b exp=%b", j + 1, speaker_out, es); end
            if (j + 1 >= T + 3 && speaker_out !== 1'b0) begin n_errors++; $display("FAIL collision.phase0 k+%0d got=%b exp=0", j + 1, speaker_out); end
        end
        pulse_in = '0;
    endtask

    task automatic test_priority_mask();
        logic [NCH-1:0] ea;
        logic es;
        int pa;
        int pb;
        quiet(T + 4);
        volume = 8'd255;
        pa = $urandom_range(4, 15);
        pb = $urandom_range(4, 15);
        for (int j = 0; j < 360; j++) begin
            ch_enable   = (j >= 120 && j < 240) ? 4'b1101 : 4'b1111;
            pulse_in[1] = (j % pa == 0);
            pulse_in[3] = (j % pb == 1);
            tick(ea, es);
            n_checks += 2;
            if (active !== ea) begin n_errors++; $display("FAIL priority.active p=%0d got=%b exp=%b", p, active, ea); end
            if (speaker_out !== es) begin n_errors++; $display("FAIL priority.speaker p=%0d got=%b exp=%b", p, speaker_out, es); end
        end
        pulse_in = '0;
    endtask

    task automatic test_volume_hold();
        logic [NCH-1:0] ea;
        logic es;
        int act_cnt;
        quiet(T + 4);
        ch_enable = '1;
        for (int j = 0; j < 600; j++) begin
            volume      = (j < 300) ? 8'd0 : 8'd64;
            pulse_in[0] = (j % 7 == 0);
            pulse_in[2] = (j % 11 == 3);
            tick(ea, es);
            n_checks += 2;
            if (speaker_out !== es || (j < 300 && speaker_out !== 1'b0)) begin
                n_errors++; $display("FAIL volume.speaker p=%0d got=%b exp=%b", p, speaker_out, es);
            end
            if (active !== ea) begin n_errors++; $display("FAIL volume.active p=%0d got=%b exp=%b", p, active, ea); end
        end
        quiet(T + 4);
        volume  = 8'd255;
        act_cnt = 0;
        for (int j = 0; j < 60; j++) begin
            pulse_in[0] = (j < 50);
            tick(ea, es);
            if (active[0] === 1'b1) act_cnt++;
            n_checks += 2;
            if (active !== ea) begin n_errors++; $display("FAIL hold.active p=%0d got=%b exp=%b", p, active, ea); end
            if (speaker_out !== es) begin n_errors++; $display("FAIL hold.speaker p=%0d got=%b exp=%b", p, speaker_out, es); end
        end
        pulse_in = '0;
        n_checks++;
        if (act_cnt !== T) begin n_errors++; $display("FAIL hold.active_cycles got=%0d exp=%0d", act_cnt, T); end
    endtask

    task automatic test_reset_midtone();
        logic [NCH-1:0] ea;
        logic es;
        ch_enable = '1;
        volume    = 8'd255;
        for (int j = 0; j < 40; j++) begin
            pulse_in[0] = (j % 5 == 0);
            pulse_in[2] = (j % 9 == 2);
            tick(ea, es);
        end
        reset_n = 1'b0;
        #1;
        n_checks += 2;
        if (active !== 4'h0) begin n_errors++; $display("FAIL midreset.active got=%b exp=0000", active); end
        if (speaker_out !== 1'b0) begin n_errors++; $display("FAIL midreset.speaker got=%b exp=0", speaker_out); end
        pulse_in = '0;
        for (int j = 0; j < 3; j++) tick(ea, es);
        reset_n  = 1'b1;
        pulse_in = 4'b0001;
        tick(ea, es);
        pulse_in = '0;
        tick(ea, es);
        n_checks += 2;
        if (speaker_out !== 1'b1) begin n_errors++; $display("FAIL midreset.first_phase got=%b exp=1", speaker_out); end
        if (active !== 4'b0001) begin n_errors++; $display("FAIL midreset.active_after got=%b exp=0001", active); end
    endtask

    task automatic test_random();
        logic [NCH-1:0] ea;
        logic es;
        int r;
        for (int j = 0; j < 1500; j++) begin
            if (j % 64 == 0) begin
                r = $urandom_range(0, 3);
                volume = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom);
            end
            if (j % 97 == 0) ch_enable = 4'($urandom);
            for (int i = 0; i < NCH; i++) pulse_in[i] = ($urandom_range(0, 9) == 0);
            tick(ea, es);
            n_checks += 2;
            if (active !== ea) begin n_errors++; $display("FAIL random.active p=%0d got=%b exp=%b", p, active, ea); end
            if (speaker_out !== es) begin n_errors++; $display("FAIL random.speaker p=%0d got=%b exp=%b", p, speaker_out, es); end
        end
        pulse_in = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        pulse_in  = '0;
        ch_enable = '1;
        volume    = 8'd0;
        p         = 0;
        for (int i = 0; i < NCH; i++) begin
            last_e[i] = -1;
            ph[i]     = 1'b0;
            prevp[i]  = 1'b0;
        end
        test_reset();
        test_single_tone();
        test_timeout();
        test_collision();
        test_priority_mask();
        test_volume_hold();
        test_reset_midtone();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/audio_output_stage.md
# audio_output_stage

Speaker-side sink for the game's sound-effect generators. Each effect generator emits a train of single-cycle pulses, one per half-period of its tone. This block converts each pulse train into a square wave, selects one channel by fixed priority, and drives the board speaker pin through a volume-scaled PWM carrier. It sits between the effect generators (jump, collision, level-complete, ...) and the top-level audio pin.

## Interface
Parameters:
- NUM_CH, default 4: number of effect channels. Index 0 has the highest priority.
- SILENCE_TIMEOUT, default 65536: number of cycles without a pulse after which a channel is declared silent. Must be ≥ 2.
- PWM_BITS, default 8: width of the PWM counter and of the volume input.

Ports:
- clk  in  1  system pixel/game clock (25.1 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- pulse_in  in  NUM_CH  per-channel pulse train from the effect generators. Rising-edge sensitive.
- ch_enable  in  NUM_CH  per-channel mute mask. 1 means the channel is eligible for output.
- volume  in  PWM_BITS  PWM duty threshold. 0 means silent.
- active  out  NUM_CH  per-channel "tone present" flags (registered).
- speaker_out  out  1  PWM-modulated square wave to the speaker pin (registered).

## Operation
- Edge detect:
  - pulse_prev[i] registers pulse_in[i].
  - edge[i] = pulse_in[i] & ~pulse_prev[i].
  - A level held high for many cycles counts as one edge.
- Per-channel state: phase[i] (1 bit), active[i] (1 bit), and silence counter cnt[i], width $clog2(SILENCE_TIMEOUT).
- Per-channel update, in priority order (first match wins):
  - If edge[i]: phase[i] toggles, cnt[i] is set to 0, active[i] is set to 1.
  - Else if active[i] and cnt[i] == SILENCE_TIMEOUT-1: active[i], phase[i] and cnt[i] are all set to 0 (timeout).
  - Else if active[i]: cnt[i] increments.
  - Else: all hold at 0.
- Output tone frequency is clk / (2 × pulse period). Example: a pulse every 28524 cycles gives a toggle every 28524 cycles, about 440 Hz.
- Selection (combinational, from registered state): sel is the lowest i with active[i] & ch_enable[i]. any_sel is set if such an i exists.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that increments every cycle and wraps from all-ones to 0.
  - pwm_hi = (pwm_cnt < volume).
- speaker_out is registered as any_sel & phase[sel] & pwm_hi.
- ch_enable affects selection only. Masked channels keep tracking their phase, counter and active flag, so unmasking resumes mid-tone in the correct phase.
- Channels are fully independent. A lower-priority channel's tone continues internally while it is pre-empted.

## Timing
- Reset (async assert, synchronous-release assumed upstream):
  - pulse_prev, phase, active, cnt, pwm_cnt and speaker_out all go to 0.
  - Outputs: active = 0, speaker_out = 0.
- Edge latency:
  - pulse_in[i] rises in cycle k.
  - phase[i] and active[i] change at the end of cycle k (visible in cycle k+1).
  - speaker_out reflects the change in cycle k+2.
- Timeout latency: with the last edge in cycle k, active[i] drops in cycle k+SILENCE_TIMEOUT+1, and speaker_out drops to 0 in the next cycle (if that channel was selected).
- Simultaneous edge and timeout in the same cycle: the edge wins. The counter restarts, phase toggles, and active stays 1.
- Reset mid-tone: all state is cleared immediately. The first edge after release starts with phase = 1.
- pwm_cnt wraps every 2^PWM_BITS cycles. Duty cycle is volume / 2^PWM_BITS, so volume all-ones gives 255/256 at PWM_BITS = 8, never 100%.
- Priority change (a higher channel becomes active or enabled) takes effect on speaker_out one cycle after the state change. There is no glitch-free crossfade.

## Test plan
- Reset: hold reset_n = 0 while pulsing all channels. Required: active = 0 and speaker_out = 0 throughout. After release, the first pulse on ch0 sets active[0] = 1 in the next cycle.
- Single tone: volume = 255, ch_enable = 4'b1111, a 1-cycle pulse on ch0 every 100 cycles. Required:
  - speaker_out is high only in alternating 100-cycle windows.
  - In a high window, 255 of each 256 cycles are high.
  - First assertion is 2 cycles after the first pulse.
- Timeout, with SILENCE_TIMEOUT = 16 for the bench: pulse ch1 once at cycle k. Required: active[1] = 1 over cycles k+1..k+16, falls at k+17, and speaker_out = 0 from k+18.
- Edge-versus-timeout collision, SILENCE_TIMEOUT = 16: pulse ch2 at k and again at k+16. Required: active[2] never drops, phase toggles back to 0, and the counter restarts.
- Priority and mask: ch3 and ch1 both toning. Required: speaker_out follows ch1. Clear ch_enable[1] → follows ch3 one cycle later. Re-enable ch1 → ch1 resumes in its correct (continued) phase.
- Volume and held level:
  - volume = 0 → speaker_out stays 0 with active channels.
  - volume = 64 → 64 high cycles per 256.
  - pulse_in held high for 50 cycles → exactly one phase toggle.
